div32_iter: RTL and testbench
=============================

# div32_iter

Iterative 32-bit integer divider, the inverse companion to the ALU's combinational 32-bit multiplier. It shares that unit's operand names and its single-bit signed/unsigned select. It computes quotient and remainder with a restoring shift-subtract algorithm at one bit per clock, behind a start/busy/done handshake. It sits beside the multiplier in the ALU; the ALU result mux selects `Quot` or `Rem` once `done` pulses.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width. Only 32 is verified.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `A`  in  32  dividend, captured on accepted start.
- `B`  in  32  divisor, captured on accepted start.
- `Ctrl`  in  1  0 = unsigned, 1 = signed two's complement; captured with operands.
- `busy`  out  1  high from the accepted-start edge until the result edge, inclusive.
- `done`  out  1  one-cycle pulse; `Quot`/`Rem` are valid in the same cycle.
- `Quot`  out  32  quotient, held until the next completion.
- `Rem`  out  32  remainder, held until the next completion.
- `div_zero`  out  1  set with `done` when B==0; held with the results.

## Operation
- Reset: state IDLE; `busy`, `done`, `div_zero` = 0; `Quot`, `Rem` = 0; internal registers cleared.
- State machine: IDLE → RUN → FIX → IDLE; IDLE → ZERO → IDLE.
- IDLE:
  - `start`=1 and B!=0 → RUN.
  - `start`=1 and B==0 → ZERO.
  - Latch operands, `Ctrl`, and the sign flags.
- Operand prep (entering RUN):
  - Signed mode: magnitudes |A|, |B| as 32-bit unsigned. |0x80000000| = 0x80000000.
  - Unsigned mode: operands used as-is.
- RUN, 32 iterations, MSB first:
  - Partial remainder r (33 bits) = {r[31:0], q[31]}; q shifts left.
  - If r ≥ divisor: r -= divisor, new q[0] = 1; else new q[0] = 0.
  - Iteration counter counts 0..31; leaves RUN after count 31.
- FIX, 1 cycle, signed mode only applies:
  - Quotient negated iff sign(A) != sign(B).
  - Remainder negated iff A negative (remainder takes the dividend's sign).
  - Registers `Quot`/`Rem`, pulses `done`.
- ZERO, 1 cycle: `Quot` = 0xFFFFFFFF, `Rem` = A (unmodified), `div_zero` = 1, `done` pulse.
- Signed overflow 0x80000000 / 0xFFFFFFFF: falls out of the algorithm as `Quot` = 0x80000000, `Rem` = 0, with no special case.
- `div_zero` is cleared on every normal completion.
- `start` while `busy` = 1 is ignored; operands are not re-sampled.
- `rst` during RUN/FIX aborts the operation: outputs return to reset values and no `done` is issued.

## Timing
- Accepting edge = edge k, where IDLE and `start`=1.
- Normal path:
  - `busy`=1 from after edge k.
  - Iterations occur on edges k+1..k+32.
  - FIX registers results on edge k+33.
  - `done`=1 for the single cycle following edge k+33.
  - `busy` drops in that same cycle.
  - Latency: 34 cycles start-to-done.
- Divide-by-zero path: `done` in the cycle after edge k+1 (2 cycles).
- Back-to-back: `start` may be held high in the `done` cycle; it is accepted on the next edge. Throughput is one operation per 34 cycles.
- `Quot`/`Rem` change only on result edges and never glitch during RUN.

## Structure
- Package `div_pkg`:
  - state enum `{IDLE, RUN, FIX, ZERO}`
  - `DIV_ITERS` = 32
  - `DIV_LATENCY` = 34
  - `DIV_ZERO_QUOT` = 32'hFFFFFFFF
- One sub-module, `div_step`: combinational single restoring iteration.
  - Inputs: 33-bit r, quotient bit-in, divisor.
  - Outputs: next r, quotient bit.
- Top level holds the FSM, counter, sign prep/fix, and output registers.

## Test plan
- Unsigned: A=100, B=7, Ctrl=0 → `done` exactly 34 cycles after start; `Quot`=14, `Rem`=2, `div_zero`=0.
- Signed: A=0xFFFFFFF9 (-7), B=2, Ctrl=1 → `Quot`=0xFFFFFFFD (-3), `Rem`=0xFFFFFFFF (-1). Repeat with A=7, B=0xFFFFFFFE → `Quot`=0xFFFFFFFD, `Rem`=1.
- Overflow/mode: A=0x80000000, B=0xFFFFFFFF.
  - Ctrl=1 → `Quot`=0x80000000, `Rem`=0.
  - Ctrl=0 → `Quot`=0, `Rem`=0x80000000.
- Divide by zero: A=0x12345678, B=0 → `done` 2 cycles after start; `Quot`=0xFFFFFFFF, `Rem`=0x12345678, `div_zero`=1. A following 10/3 clears `div_zero`.
- Handshake: pulse `start` with new operands at cycle 10 of a busy operation → ignored; first result unaffected; `done` pulses once.
- Reset mid-op: assert `rst` at cycle 15 of RUN → next cycle `busy`=0, `Quot`=`Rem`=0, no `done`; a fresh start then completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ZERO
  } div_state_e;

  localparam int unsigned DIV_ITERS     = 32;
  localparam int unsigned DIV_LATENCY   = 34;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Magnitude of a two's complement value when signed; 0x80000000 maps onto itself.
  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           unused_msb;

  // The partial remainder stays below the divisor, so its top bit is always shifted out.
  assign unused_msb = r[WIDTH];
  assign shifted    = {r[WIDTH-1:0], q_in};
  assign diff       = shifted - {1'b0, divisor};
  assign q_out      = (shifted >= {1'b0, divisor});
  assign r_next     = q_out ? diff : shifted;

endmodule

// File: rtl/div32_iter.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock, start/busy/done handshake.
module div32_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV_ITERS - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   step_r;
  logic             step_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r      (r_q),
    .q_in   (q_q[WIDTH-1]),
    .divisor(divisor_q),
    .r_next (step_r),
    .q_out  (step_q)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d  = div_abs(B, Ctrl);
          r_d        = '0;
          cnt_d      = '0;
          neg_quot_d = Ctrl & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d  = Ctrl & A[WIDTH-1];
          // q doubles as the raw dividend holder on the divide-by-zero path.
          if (B == '0) begin
            q_d     = A;
            state_d = ZERO;
          end else begin
            q_d     = div_abs(A, Ctrl);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = FIX;
      end
      FIX: begin
        quot_d  = neg_quot_q ? (~q_q + 1'b1) : q_q;
        rem_d   = neg_rem_q ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
        done_d  = 1'b1;
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      ZERO: begin
        quot_d  = DIV_ZERO_QUOT;
        rem_d   = q_q;
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      q_q        <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign Quot     = quot_q;
  assign Rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div32_iter.sv
// Scoreboard bench for div32_iter: directed corner cases plus random operands vs an arithmetic model.
module tb_div32_iter;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ctrl = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] quot, rem;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        scb[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_dz = 1'b0;

  div32_iter #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (a),
    .B       (b),
    .Ctrl    (ctrl),
    .busy    (busy),
    .done    (done),
    .Quot    (quot),
    .Rem     (rem),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   e;
    longint sx, sy, qq, rr;
    e.cyc = 0;
    if (y == 0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = x;
      e.dz = 1'b1;
    end else if (s) begin
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      qq   = sx / sy;
      rr   = sx % sy;
      e.q  = qq[31:0];
      e.r  = rr[31:0];
      e.dz = 1'b0;
    end else begin
      e.q  = x / y;
      e.r  = x % y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input exp_t e_in);
    exp_t e;
    int   n;
    e = e_in;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: actual busy=1 required busy=0");
    end
    a     = x;
    b     = y;
    ctrl  = s;
    start = 1'b1;
    e.cyc = cyc + 1 + ((y == 0) ? 1 : div_pkg::DIV_LATENCY - 1);
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [31:0] x, input logic [31:0] y, input logic s);
    issue(x, y, s, model(x, y, s));
  endtask

  // Monitor: pops on done, otherwise checks that results are held steady.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_q  <= '0;
      last_r  <= '0;
      last_dz <= 1'b0;
    end else if (done) begin
      if (scb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 required done=0");
      end else begin
        e = scb.pop_front();
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        chk("latency_cycle", cyc, e.cyc);
        last_q  <= e.q;
        last_r  <= e.r;
        last_dz <= e.dz;
      end
    end else begin
      chk("quot_hold", quot, last_q);
      chk("rem_hold", rem, last_r);
      chk("div_zero_hold", {31'd0, div_zero}, {31'd0, last_dz});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] x, y;
    logic        s;
    int unsigned sel;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quot", quot, 32'd0);
    chk("reset_rem", rem, 32'd0);
    chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0, cyc: 0});
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0, cyc: 0});
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0, cyc: 0});
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, cyc: 0});
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0, cyc: 0});
    issue(32'h1234_5678, 32'd0, 1'b0, '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1, cyc: 0});
    issue(32'd10, 32'd3, 1'b0, '{q: 32'd3, r: 32'd1, dz: 1'b0, cyc: 0});

    // A start pulse mid-operation must be ignored.
    issue(32'd1000, 32'd33, 1'b0, '{q: 32'd30, r: 32'd10, dz: 1'b0, cyc: 0});
    repeat (8) @(negedge clk);
    a     = 32'd5;
    b     = 32'd1;
    ctrl  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of RUN aborts without a done pulse.
    issue(32'hDEAD_BEEF, 32'd17, 1'b0, model(32'hDEAD_BEEF, 32'd17, 1'b0));
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quot", quot, 32'd0);
    chk("abort_rem", rem, 32'd0);
    scb.delete();
    rst = 1'b0;
    issue(32'd10, 32'd3, 1'b0, '{q: 32'd3, r: 32'd1, dz: 1'b0, cyc: 0});

    for (int i = 0; i < 40; i++) begin
      x   = $urandom;
      y   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'h8000_0000;
        4: y = x >> $urandom_range(0, 31);
        default: ;
      endcase
      issue_model(x, y, s);
    end

    n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", scb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
